// File: rtl/seg_pkg.sv
// Shared constants for 7-segment scan monitors: segment codes, digit selects, causes, states.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] SEL_IDX0  = 4'b1110;
  localparam logic [3:0] SEL_IDX1  = 4'b1101;
  localparam logic [3:0] SEL_IDX2  = 4'b1011;
  localparam logic [3:0] SEL_IDX3  = 4'b0111;
  localparam logic [3:0] SEL_BLANK = 4'b1111;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_MULTI   = 3'd1,
    ERR_BADCODE = 3'd2,
    ERR_ORDER   = 3'd3,
    ERR_RANGE   = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_cause_t;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/segment_decode.sv
// Combinational 7-segment code to BCD digit; valid=0 for any non-digit pattern.
module segment_decode
  import seg_pkg::*;
(
  input  logic [6:0] code,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    digit = 4'd0;
    case (code)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// Rebuilds {hi,lo} 6-bit fields from a scanned 4-digit 7-segment bus; outputs registered,
// one edge of latency after the final digit; no backpressure, the bus is sampled on sample_en.
module segment_scan_decoder
  import seg_pkg::*;
#(
  parameter int TIMEOUT_SAMPLES = 16,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [3:0]           bytee,
  input  logic [6:0]           segment,
  output logic [11:0]          data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic [2:0]           err_cause,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(TIMEOUT_SAMPLES + 1);

  state_t         state;
  err_cause_t     cause_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]     exp_idx;
  logic [3:0]     lo_u, lo_t, hi_u;

  logic           code_vld;
  logic [3:0]     digit;
  logic           sel_one, sel_multi;
  logic [1:0]     sel_idx;
  logic [1:0]     last_idx;
  logic           same, prog, ooo;
  logic [3:0]     units;
  logic [6:0]     field, lo_field;
  logic           range_bad;
  logic [CNT_W-1:0] cnt_next;
  err_cause_t     col_err;

  segment_decode u_dec (
    .code  (segment),
    .valid (code_vld),
    .digit (digit)
  );

  always_comb begin
    sel_one   = 1'b0;
    sel_multi = 1'b0;
    sel_idx   = 2'd0;
    case (bytee)
      SEL_IDX0:  begin sel_one = 1'b1; sel_idx = 2'd0; end
      SEL_IDX1:  begin sel_one = 1'b1; sel_idx = 2'd1; end
      SEL_IDX2:  begin sel_one = 1'b1; sel_idx = 2'd2; end
      SEL_IDX3:  begin sel_one = 1'b1; sel_idx = 2'd3; end
      SEL_BLANK: sel_one = 1'b0;
      default:   sel_multi = 1'b1;
    endcase
  end

  // Tens digits sit on odd indices; their units partner is the digit just below.
  always_comb begin
    last_idx  = exp_idx - 2'd1;
    same      = sel_one && (sel_idx == last_idx);
    prog      = sel_one && (sel_idx == exp_idx);
    ooo       = sel_one && !same && !prog;
    units     = (sel_idx == 2'd1) ? lo_u : hi_u;
    field     = {3'b000, digit} * 7'd10 + {3'b000, units};
    lo_field  = {3'b000, lo_t} * 7'd10 + {3'b000, lo_u};
    range_bad = (digit > 4'd6) || (field > 7'd63);
    cnt_next  = tmo_cnt + CNT_W'(1);

    col_err = ERR_NONE;
    if (sel_multi)
      col_err = ERR_MULTI;
    else if (sel_one && !code_vld)
      col_err = ERR_BADCODE;
    else if (ooo)
      col_err = ERR_ORDER;
    else if ((same || prog) && sel_idx[0] && range_bad)
      col_err = ERR_RANGE;
    else if (!prog && (cnt_next == CNT_W'(TIMEOUT_SAMPLES)))
      col_err = ERR_TIMEOUT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HUNT;
      cause_q     <= ERR_NONE;
      tmo_cnt     <= '0;
      exp_idx     <= 2'd1;
      lo_u        <= '0;
      lo_t        <= '0;
      hi_u        <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      err_count   <= '0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (sample_en) begin
        case (state)
          HUNT: begin
            if (sel_one && code_vld && (sel_idx == 2'd0)) begin
              lo_u    <= digit;
              exp_idx <= 2'd1;
              tmo_cnt <= '0;
              state   <= COLLECT;
            end
          end
          COLLECT: begin
            if (col_err != ERR_NONE) begin
              frame_error <= 1'b1;
              cause_q     <= col_err;
              tmo_cnt     <= '0;
              if (err_count != '1)
                err_count <= err_count + ERR_CNT_W'(1);
              // An early idx0 means the scan wrapped: resync on it rather than hunt.
              if ((col_err == ERR_ORDER) && (sel_idx == 2'd0)) begin
                lo_u    <= digit;
                exp_idx <= 2'd1;
              end else begin
                state <= HUNT;
              end
            end else if (sel_one) begin
              case (sel_idx)
                2'd0:    lo_u <= digit;
                2'd1:    lo_t <= digit;
                2'd2:    hi_u <= digit;
                default: ;
              endcase
              if (prog) begin
                tmo_cnt <= '0;
                exp_idx <= exp_idx + 2'd1;
                if (sel_idx == 2'd3) begin
                  data_out   <= {field[5:0], lo_field[5:0]};
                  data_valid <= 1'b1;
                  state      <= HUNT;
                end
              end else begin
                tmo_cnt <= cnt_next;
              end
            end else begin
              tmo_cnt <= cnt_next;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign err_cause = cause_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed plus randomized bench for segment_scan_decoder against a digit-list reference model.
module tb_segment_scan_decoder;

  localparam int TMO = 16;
  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0;
  logic [3:0]  bytee = 4'b1111;
  logic [6:0]  segment = 7'h00;
  logic [11:0] data_out;
  logic        data_valid;
  logic        frame_error;
  logic [2:0]  err_cause;
  logic [7:0]  err_count;

  segment_scan_decoder #(.TIMEOUT_SAMPLES(TMO), .ERR_CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_en   (sample_en),
    .bytee       (bytee),
    .segment     (segment),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .err_cause   (err_cause),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int seen_valid = 0;

  // Reference model: list of accepted digits so far (m_n of them, 0 = hunting).
  int          m_n = 0;
  int          m_dig [4];
  int          m_idle = 0;
  logic [11:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_ferr = 1'b0;
  logic [2:0]  m_cause = '0;
  logic [7:0]  m_count = '0;

  int r, r2, cur, idx, dg, vbase;
  logic [3:0] rb;
  logic [6:0] rs;

  task automatic model_reset();
    m_n = 0; m_idle = 0; m_data = '0; m_valid = 1'b0; m_ferr = 1'b0;
    m_cause = '0; m_count = '0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] b, input logic [6:0] s);
    int zeros, pos, d, cause;
    bit restart, progress;
    int lo, hi;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (!en) return;
    zeros = 4 - $countones(b);
    pos = -1;
    if (zeros == 1)
      for (int i = 0; i < 4; i++) if (!b[i]) pos = i;
    d = -1;
    for (int i = 0; i < 10; i++) if (CODES[i] == s) d = i;
    if (m_n == 0) begin
      if (pos == 0 && d >= 0) begin m_dig[0] = d; m_n = 1; m_idle = 0; end
      return;
    end
    cause = 0;
    restart = 0;
    if (zeros >= 2) cause = 1;
    else if (zeros == 1 && d < 0) cause = 2;
    else if (zeros == 1 && pos != m_n && pos != m_n - 1) begin
      cause = 3;
      restart = (pos == 0);
    end else if (zeros == 1 && (pos == 1 || pos == 3)) begin
      if (d > 6 || d * 10 + m_dig[pos-1] > 63) cause = 4;
    end
    if (cause == 0) begin
      progress = (zeros == 1) && (pos == m_n);
      if (!progress) begin
        m_idle++;
        if (m_idle == TMO) cause = 5;
      end
    end
    if (cause != 0) begin
      m_ferr = 1'b1;
      m_cause = 3'(cause);
      if (m_count != 8'd255) m_count++;
      if (restart) begin m_dig[0] = d; m_n = 1; m_idle = 0; end
      else m_n = 0;
      return;
    end
    if (zeros == 1) begin
      m_dig[pos] = d;
      if (pos == m_n) begin
        m_n++;
        m_idle = 0;
        if (m_n == 4) begin
          lo = m_dig[1] * 10 + m_dig[0];
          hi = m_dig[3] * 10 + m_dig[2];
          m_data = {6'(hi), 6'(lo)};
          m_valid = 1'b1;
          m_n = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    if (data_valid === 1'b1) seen_valid++;
    checks++;
    assert (data_out === m_data) else begin
      errors++; $error("FAIL %s data_out: got %h want %h", tag, data_out, m_data);
    end
    checks++;
    assert (data_valid === m_valid) else begin
      errors++; $error("FAIL %s data_valid: got %b want %b", tag, data_valid, m_valid);
    end
    checks++;
    assert (frame_error === m_ferr) else begin
      errors++; $error("FAIL %s frame_error: got %b want %b", tag, frame_error, m_ferr);
    end
    checks++;
    assert (err_cause === m_cause) else begin
      errors++; $error("FAIL %s err_cause: got %0d want %0d", tag, err_cause, m_cause);
    end
    checks++;
    assert (err_count === m_count) else begin
      errors++; $error("FAIL %s err_count: got %0d want %0d", tag, err_count, m_count);
    end
    checks++;
    assert (!(data_valid === 1'b1 && frame_error === 1'b1)) else begin
      errors++; $error("FAIL %s valid_and_error: got both high want exclusive", tag);
    end
  endtask

  task automatic expect_val(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++; $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic [6:0] s, input logic en, input string tag);
    bytee = b; segment = s; sample_en = en;
    @(posedge clock);
    model_step(en, b, s);
    #1;
    check_all(tag);
  endtask

  task automatic sel(input int i, input logic [6:0] s, input string tag);
    logic [3:0] one;
    one = 4'b0001 << i;
    step(~one, s, 1'b1, tag);
  endtask

  task automatic blank(input string tag);
    step(4'b1111, 7'h00, 1'b1, tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clock);
    model_reset();
    #1;
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    do_reset("reset");

    // 0x5ED: 5,4,3,2 each held three samples with a blank after
    vbase = seen_valid;
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 3; h++) sel(k, CODES[5 - k], "scan5ed");
      blank("scan5ed_blank");
    end
    expect_val("val_5ed", int'(data_out), 'h5ED);
    expect_val("cnt_5ed", int'(err_count), 0);
    expect_val("pulses_5ed", seen_valid - vbase, 1);

    // latest sample in a slot wins
    sel(0, CODES[1], "mid"); sel(0, CODES[0], "mid");
    sel(1, CODES[1], "mid"); sel(2, CODES[0], "mid"); sel(3, CODES[0], "mid");
    expect_val("val_mid", int'(data_out), 'h00A);

    // multi-select, then 59/59
    sel(0, CODES[3], "multi"); step(4'b1100, CODES[3], 1'b1, "multi");
    expect_val("cause_multi", int'(err_cause), 1);
    sel(0, CODES[9], "5959"); sel(1, CODES[5], "5959");
    sel(2, CODES[9], "5959"); sel(3, CODES[5], "5959");
    expect_val("val_efb", int'(data_out), 'hEFB);

    // out-of-order, and idx0 restart
    sel(0, CODES[1], "ooo"); sel(2, CODES[1], "ooo");
    expect_val("cause_ooo", int'(err_cause), 3);
    sel(0, CODES[1], "rst0"); sel(1, CODES[2], "rst0"); sel(0, CODES[3], "rst0");
    sel(1, CODES[1], "rst0"); sel(2, CODES[4], "rst0"); sel(3, CODES[5], "rst0");
    expect_val("val_restart", int'(data_out), {6'd54, 6'd13});

    // range errors leave data_out alone
    sel(0, CODES[4], "range"); sel(1, CODES[6], "range");
    expect_val("cause_range64", int'(err_cause), 4);
    sel(0, CODES[0], "range"); sel(1, CODES[7], "range");
    expect_val("cause_tens7", int'(err_cause), 4);
    expect_val("val_after_range", int'(data_out), {6'd54, 6'd13});

    // bad code, sample_en low holds
    sel(0, CODES[2], "bad"); step(4'b1101, 7'h00, 1'b0, "hold"); sel(1, 7'h7E, "bad");
    expect_val("cause_bad", int'(err_cause), 2);

    // timeout: fifteen idle samples tolerated, sixteenth aborts
    sel(0, CODES[2], "tmo");
    for (int k = 0; k < TMO; k++) blank("tmo");
    expect_val("cause_tmo", int'(err_cause), 5);

    // randomized scan traffic
    cur = 0;
    for (int k = 0; k < 2000; k++) begin
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 99);
      if (r2 < 72) begin
        idx = cur;
        if ($urandom_range(0, 2) == 0) cur = (cur + 1) % 4;
        rb = ~(4'b0001 << idx);
      end else if (r2 < 82) begin
        idx = 0; rb = 4'b1111;
      end else if (r2 < 92) begin
        idx = $urandom_range(0, 3); rb = ~(4'b0001 << idx);
      end else begin
        idx = 0; rb = 4'($urandom);
      end
      dg = (idx % 2 == 1) ? $urandom_range(0, 6) : $urandom_range(0, 9);
      rs = ($urandom_range(0, 99) < 93) ? CODES[dg] : 7'($urandom);
      step(rb, rs, r < 80, "rand");
    end

    // saturation
    for (int k = 0; k < 300; k++) begin
      sel(0, CODES[1], "sat"); step(4'b1100, CODES[1], 1'b1, "sat");
    end
    expect_val("cnt_sat", int'(err_count), 255);

    // reset mid-frame, then a partial scan must not complete
    sel(0, CODES[1], "midrst"); sel(1, CODES[1], "midrst");
    do_reset("midrst_reset");
    expect_val("rst_data", int'(data_out), 0);
    expect_val("rst_count", int'(err_count), 0);
    sel(2, CODES[1], "post_rst"); sel(3, CODES[1], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/segment_scan_decoder.md
Name: segment_scan_decoder

Overview:
Monitors the multiplexed 7-segment output bus (active-low digit selects plus segment code) and reconstructs the 12-bit displayed value: two 6-bit fields, each shown as units and tens digits. It is the decode/readback end of the display driver. It serves as an on-chip loopback self-test and as a bench monitor for the clock display. It tracks scan order, decodes segment patterns back to digits, validates range and sequence, and emits complete frames with error reporting.

Parameters:
TIMEOUT_SAMPLES, 16, number of sample_en strobes allowed in COLLECT without accepting the next digit before the frame is aborted
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_en  input  1  bus-stable strobe; bytee/segment are sampled only on edges where this is 1
bytee  input  4  digit selects, active low: 1110=idx0, 1101=idx1, 1011=idx2, 0111=idx3, 1111=blank
segment  input  7  segment code, active high, bit0=a … bit6=g
data_out  output  12  last valid frame {hi[5:0], lo[5:0]}; holds between frames
data_valid  output  1  one-cycle pulse when data_out is updated
frame_error  output  1  one-cycle pulse on any frame abort
err_cause  output  3  cause of the most recent abort (held): 1 multi-select, 2 bad code, 3 out-of-order, 4 range, 5 timeout
err_count  output  ERR_CNT_W  aborts since reset, saturating

Behaviour:
- Reset is synchronous and active-high; it takes priority over every other event, including an in-progress frame. On reset: state=HUNT, data_out=0, data_valid=0, frame_error=0, err_cause=0, err_count=0, timeout counter=0, digit registers=0.
- All decisions happen on an edge with sample_en=1. With sample_en=0, state and registers hold, and pulses drop to 0.
- Segment decode (digit 0..9): 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9. Any other code while a single digit is selected raises a bad-code error.
- Select decode:
  - Exactly one zero in bytee gives the index.
  - bytee=1111 is blank: no digit is accepted, and the timeout counter still advances in COLLECT.
  - Two or more zeros raise a multi-select error.
- Digit meaning: idx0=lo units, idx1=lo tens, idx2=hi units, idx3=hi tens.
- HUNT state:
  - Stay in HUNT until a valid idx0 sample arrives; store its units value, then go to COLLECT with expected next index=1.
  - Any other index is ignored with no error.
  - Multi-select and bad-code errors are ignored in HUNT.
- COLLECT state:
  - Same index as the last accepted digit: the value overwrites (latest wins). This is not progress.
  - Index equal to expected: accept the digit, clear the timeout counter, and advance expected.
  - Any other index: out-of-order error.
  - Exception: an out-of-order idx0 still raises the error pulse and increments err_count, but then restarts the frame immediately from that sample (COLLECT, expected=1) instead of going to HUNT.
- Range check, applied when idx1 or idx3 is accepted:
  - field = tens*10 + units, computed 7 bits wide.
  - tens>6 or field>63 is a range error.
- Frame completion: when idx3 is accepted without error, on the same edge data_out <= {hi_field, lo_field}, data_valid=1 for one cycle, and state returns to HUNT.
- Timeout: in COLLECT, each sample_en without progress increments the counter. When the counter reaches TIMEOUT_SAMPLES, raise a timeout error.
- Error action:
  - frame_error=1 for one cycle, err_cause updated, err_count incremented (saturates at 2^ERR_CNT_W-1).
  - state=HUNT (except the idx0 restart above); data_out is unchanged.
- Simultaneous conditions: priority is multi-select > bad code > out-of-order > range. A timeout is raised only on an otherwise error-free sample.
- data_valid and frame_error are never both 1.

Decomposition:
- Package seg_pkg holds:
  - the 10 segment-code constants and digit-select constants;
  - the err_cause enum;
  - the state typedef {HUNT, COLLECT}.
- One natural sub-module: segment_decode. It is combinational, maps code[6:0] to {valid, digit[3:0]}, and can be reused by other monitors.

Test Plan:
- Value 0x5ED: scan idx0=0x6D(5), idx1=0x66(4), idx2=0x4F(3), idx3=0x5B(2), each held 3 samples with a blank between → one data_valid, data_out=0x5ED, err_count=0.
- Mid-slot change: idx0 sampled as 0x06 then 0x3F, then idx1=0x06, idx2=0x3F, idx3=0x3F → data_out={6'd0,6'd10}=0x00A (latest wins).
- bytee=1100 during COLLECT → frame_error, err_cause=1, HUNT. A following valid idx0→idx3 scan of 59/59 gives data_out=0xEFB.
- Order idx0, idx2 → err_cause=3, HUNT. Order idx0, idx1, idx0 → error pulse, then the frame restarts, and a following idx1..idx3 completes it.
- Range: idx0=4 (0x66), idx1=6 (0x7D) → field 64 → err_cause=4. Tens=7 (0x07) → err_cause=4. data_out remains at its previous value.
- Timeout and reset: idx0 then 16 blank samples → err_cause=5. Reset asserted mid-frame → all outputs 0. 300 forced errors → err_count=255.
